// File: rtl/if_stage_ibuf_pkg.sv
// rtl/if_stage_ibuf_pkg.sv - shared fetch-stage constants and IBUF entry layout
package if_stage_ibuf_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam logic [1:0]  SRAM_SIZE_WORD   = 2'b10;

  localparam int PC_W         = 32;
  localparam int INST_W       = 32;
  localparam int ADEF_W       = 1;
  localparam int IBUF_ENTRY_W = PC_W + INST_W + ADEF_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [ADEF_W-1:0] adef;
  } ibuf_entry_t;

endpackage

// File: rtl/if_stage_ibuf_if.sv
// rtl/if_stage_ibuf_if.sv - split req/addr_ok/data_ok instruction SRAM bus
interface if_stage_ibuf_if;

  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

endinterface

// File: rtl/if_stage_ibuf_sync_fifo.sv
// rtl/if_stage_ibuf_sync_fifo.sv - count-based synchronous FIFO with clear
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/if_stage_ibuf.sv
// rtl/if_stage_ibuf.sv - pipelined instruction fetch with IBUF, redirect cancellation and ADEF tagging
module if_stage_ibuf
  import if_stage_ibuf_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ds_allowin,
  output logic            fs_to_ds_valid,
  output logic [31:0]     fs_pc,
  output logic [31:0]     fs_inst,
  output logic            fs_excp_adef,
  input  logic            br_taken,
  input  logic [31:0]     br_target,
  input  logic            flush,
  input  logic [31:0]     flush_target,
  if_stage_ibuf_if.master inst_sram
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IW = $clog2(IBUF_DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d, outs_after_resp;
  logic [OW-1:0] cancel_q, cancel_d;
  logic          stall_adef_q, stall_adef_d;

  logic          redirect, pc_aligned, has_credit, handshake, resp;
  logic          drop_marked, resp_keep, adef_push;
  logic [31:0]   redirect_target;

  ibuf_entry_t   ibuf_wdata, ibuf_head;
  logic          ibuf_push, ibuf_pop, ibuf_full, ibuf_empty;
  logic [IW-1:0] ibuf_count;
  logic [31:0]   tag_pc;
  logic          tag_full, tag_empty;
  logic [OW-1:0] tag_count;

  assign inst_sram.inst_sram_wr    = 1'b0;
  assign inst_sram.inst_sram_size  = SRAM_SIZE_WORD;
  assign inst_sram.inst_sram_wstrb = 4'h0;
  assign inst_sram.inst_sram_wdata = 32'h0;
  assign inst_sram.inst_sram_addr  = fetch_pc_q;

  always_comb begin
    redirect        = flush || br_taken;
    redirect_target = flush ? flush_target : br_target;
    pc_aligned      = (fetch_pc_q[1:0] == 2'b00);
    // Outstanding requests reserve IBUF slots so a response never needs backpressure.
    has_credit      = !tag_full &&
                      ((32'(outstanding_q) + 32'(ibuf_count)) < 32'(IBUF_DEPTH));
    inst_sram.inst_sram_req = !reset && !redirect && !stall_adef_q && pc_aligned && has_credit;
    handshake       = inst_sram.inst_sram_req && inst_sram.inst_sram_addr_ok;
    resp            = inst_sram.inst_sram_data_ok;
    drop_marked     = resp && (cancel_q != '0);
    resp_keep       = resp && !redirect && (cancel_q == '0);
    adef_push       = !reset && !redirect && !stall_adef_q && !pc_aligned &&
                      (outstanding_q == '0) && (cancel_q == '0) && !ibuf_full;

    ibuf_push       = resp_keep || adef_push;
    ibuf_pop        = fs_to_ds_valid && ds_allowin && !redirect;
    ibuf_wdata      = '0;
    if (adef_push) begin
      ibuf_wdata.pc   = fetch_pc_q;
      ibuf_wdata.adef = 1'b1;
    end else begin
      ibuf_wdata.pc   = tag_pc;
      ibuf_wdata.inst = inst_sram.inst_sram_rdata;
    end

    outs_after_resp = outstanding_q - OW'(resp);
    outstanding_d   = outs_after_resp + OW'(handshake);
    // Every response still in flight at a redirect is stale, including already-marked ones.
    cancel_d        = redirect ? outs_after_resp : (cancel_q - OW'(drop_marked));

    fetch_pc_d      = fetch_pc_q;
    if (redirect)       fetch_pc_d = redirect_target;
    else if (handshake) fetch_pc_d = fetch_pc_q + 32'd4;
    stall_adef_d    = redirect ? 1'b0 : (stall_adef_q || adef_push);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      cancel_q      <= '0;
      stall_adef_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      cancel_q      <= cancel_d;
      stall_adef_q  <= stall_adef_d;
    end
  end

  sync_fifo #(.WIDTH(IBUF_ENTRY_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .push  (ibuf_push),
    .pop   (ibuf_pop),
    .clear (redirect),
    .wdata (ibuf_wdata),
    .rdata (ibuf_head),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (ibuf_count)
  );

  sync_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .push  (handshake),
    .pop   (resp),
    .clear (1'b0),
    .wdata (fetch_pc_q),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign fs_to_ds_valid = !reset && !ibuf_empty;
  assign fs_pc          = fs_to_ds_valid ? ibuf_head.pc   : 32'h0;
  assign fs_inst        = fs_to_ds_valid ? ibuf_head.inst : 32'h0;
  assign fs_excp_adef   = fs_to_ds_valid ? ibuf_head.adef : 1'b0;

  assert property (@(posedge clk) disable iff (reset) !(resp && tag_empty));
  assert property (@(posedge clk) disable iff (reset) tag_count == outstanding_q);

endmodule
